// File: rtl/mcu_gpio_link_rx_pkg.sv
// Shared types and constants for the MCU GPIO serial link receiver.
package mcu_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } link_state_e;

    localparam int unsigned SCK_IDX = 0;
    localparam int unsigned SDO_IDX = 1;
    localparam int unsigned CS_IDX  = 2;

    // Value each line takes when its output enable is released: SCK=0, SDO=0, CS_N=1
    localparam logic [2:0] LINE_IDLE = 3'b100;

    function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mcu_gpio_link_rx_sync.sv
// Masks undriven MCU lines to idle, synchronizes them, and detects SCK/CS_N edges.
module mcu_link_sync
    import mcu_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] gpio_out,
    input  logic [2:0] gpio_oe_n,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       sdo
);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0]                  hist_q, hist_d;
    logic [2:0]                  masked;
    logic [2:0]                  cur;

    assign masked = (gpio_out & ~gpio_oe_n) | (LINE_IDLE & gpio_oe_n);
    assign cur    = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = masked;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        // History keeps only the two lines that need edge detection: {CS_N, SCK}
        hist_d = {cur[CS_IDX], cur[SCK_IDX]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE}};
            hist_q <= {LINE_IDLE[CS_IDX], LINE_IDLE[SCK_IDX]};
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sck_rise =  cur[SCK_IDX] & ~hist_q[0];
    assign sck_fall = ~cur[SCK_IDX] &  hist_q[0];
    assign cs_fall  = ~cur[CS_IDX]  &  hist_q[1];
    assign cs_rise  =  cur[CS_IDX]  & ~hist_q[1];
    assign sdo      =  cur[SDO_IDX];

endmodule

// File: rtl/mcu_gpio_link_rx.sv
// Fabric-side slave for the MCU bit-banged link: decodes frames into register
// read/write strobes and shifts read data back on mcu_sdi.
module mcu_gpio_link_rx
    import mcu_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mcu_gpio_out,
    input  logic [2:0]        mcu_gpio_oe_n,
    output logic              mcu_sdi,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned FLEN  = frame_len(ADDR_W, DATA_W);
    localparam int unsigned CNT_W = $clog2(FLEN + 1);
    localparam logic [CNT_W-1:0] RD_POINT = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] FLEN_C   = CNT_W'(FLEN);

    logic sck_rise, sck_fall, cs_fall, cs_rise, sdo;

    mcu_link_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .gpio_out (mcu_gpio_out),
        .gpio_oe_n(mcu_gpio_oe_n),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .sdo      (sdo)
    );

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_nxt;
    logic [FLEN-1:0]   shift_q, shift_d, shift_nxt;
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_active_q, rd_active_d;
    logic              extra_q, extra_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign shift_nxt = {shift_q[FLEN-2:0], sdo};
    assign cnt_nxt   = bit_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rd_shift_d  = rd_shift_q;
        rd_pend_d   = rd_en_q;
        rd_active_d = rd_active_q;
        extra_d     = extra_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_SHIFT;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    rd_active_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                // CS_N rising takes priority over a coincident SCK rise
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sck_rise) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = cnt_nxt;
                    if (cnt_nxt == RD_POINT && shift_nxt[ADDR_W]) begin
                        addr_d      = shift_nxt[ADDR_W-1:0];
                        rd_en_d     = 1'b1;
                        rd_active_d = 1'b1;
                    end
                    if (cnt_nxt == FLEN_C) begin
                        state_d = ST_DONE;
                        extra_d = 1'b0;
                        if (!shift_nxt[FLEN-1]) begin
                            addr_d  = shift_nxt[DATA_W +: ADDR_W];
                            wdata_d = shift_nxt[DATA_W-1:0];
                            wr_en_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise && !extra_q) begin
                    frame_err_d = 1'b1;
                    extra_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Falls only shift once the MCU has sampled a data bit, so bit DATA_W-1
        // survives the fall that follows the address phase.
        if (state_q != ST_IDLE && rd_pend_q) begin
            rd_shift_d = reg_rd_data;
        end else if (rd_active_q && sck_fall && bit_cnt_q > RD_POINT) begin
            rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
        end
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            rd_shift_d = '0;
        end

        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_shift_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_active_q <= 1'b0;
            extra_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_shift_q  <= rd_shift_d;
            rd_pend_q   <= rd_pend_d;
            rd_active_q <= rd_active_d;
            extra_q     <= extra_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mcu_sdi   = rd_shift_q[DATA_W-1];
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mcu_gpio_link_rx.sv
// Scoreboard bench for mcu_gpio_link_rx: an MCU-side driver pushes expected
// strobes/errors, a monitor pops and compares them as the DUT emits them.
module tb_mcu_gpio_link_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] gpio = 3'b100;
    logic [2:0] oe_n = 3'b000;
    logic       mcu_sdi;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'hE1;
    logic       frame_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int       kind;   // 0 write, 1 read, 2 frame error
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] ecnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_err = 8'd0;
    logic [7:0] rd_val  = 8'h00;
    logic       rd_pend = 1'b0;

    mcu_gpio_link_rx #(
        .SYNC_STAGES(2),
        .ADDR_W     (7),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mcu_gpio_out (gpio),
        .mcu_gpio_oe_n(oe_n),
        .mcu_sdi      (mcu_sdi),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .frame_err    (frame_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic hw(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int kind, input logic [6:0] a, input logic [7:0] d, input logic [7:0] e);
        exp_t x;
        x.kind = kind;
        x.addr = a;
        x.data = d;
        x.ecnt = e;
        exp_q.push_back(x);
    endtask

    task automatic bump_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        push(2, '0, '0, exp_err);
    endtask

    // Registered peripheral: data valid exactly one cycle after reg_rd_en, garbage otherwise
    initial begin
        forever begin
            @(negedge clk);
            reg_rd_data = rd_pend ? rd_val : 8'hE1;
            rd_pend     = reg_rd_en;
        end
    end

    task automatic handle(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == 0) begin
                chk("wr_addr", reg_addr, e.addr);
                chk("wr_data", reg_wdata, e.data);
            end else if (kind == 1) begin
                chk("rd_addr", reg_addr, e.addr);
            end else begin
                chk("err_cnt_at_err", err_cnt, e.ecnt);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reg_wr_en) handle(0);
                if (reg_rd_en) handle(1);
                if (frame_err) handle(2);
            end
        end
    end

    // MCU side: SCK half-period 8 clk, SDO set at start of the low phase
    task automatic frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         input int nrise, input logic masked);
        logic [15:0] f;
        f = {rw, a, d};
        if (!masked) begin
            if (rw && nrise >= 8) push(1, a, '0, '0);
            if (!rw && nrise >= 16) push(0, a, d, '0);
            if (nrise != 16) bump_err();
        end
        gpio[2] = 1'b0;
        hw(8);
        for (int i = 1; i <= nrise; i++) begin
            gpio[1] = (i <= 16) ? f[16-i] : 1'b0;
            hw(8);
            if (!masked && rw && i >= 9 && i <= 16)
                chk("sdi_read_bit", mcu_sdi, rd_val[16-i]);
            else
                chk("sdi_idle_zero", mcu_sdi, 1'b0);
            gpio[0] = 1'b1;
            hw(8);
            gpio[0] = 1'b0;
        end
        hw(8);
        gpio[1] = 1'b0;
        gpio[2] = 1'b1;
        hw(12);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish by 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        hw(3);
        chk("rst_sdi", mcu_sdi, 1'b0);
        chk("rst_addr", reg_addr, 7'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_wr_en", reg_wr_en, 1'b0);
        chk("rst_rd_en", reg_rd_en, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h00);
        rst = 1'b0;
        hw(6);

        frame(1'b0, 7'h05, 8'hA3, 16, 1'b0);

        rd_val = 8'h5C;
        frame(1'b1, 7'h12, 8'h00, 16, 1'b0);
        chk("sdi_after_read", mcu_sdi, 1'b0);

        frame(1'b0, 7'h33, 8'h11, 10, 1'b0);
        chk("err_cnt_abort", err_cnt, 8'd1);
        frame(1'b0, 7'h21, 8'h4B, 16, 1'b0);

        frame(1'b0, 7'h44, 8'hC7, 17, 1'b0);
        chk("err_cnt_extra", err_cnt, 8'd2);

        oe_n = 3'b111;
        frame(1'b0, 7'h66, 8'h99, 16, 1'b1);
        frame(1'b1, 7'h12, 8'h00, 16, 1'b1);
        gpio = 3'b100;
        hw(4);
        oe_n = 3'b000;
        hw(8);
        chk("err_cnt_masked", err_cnt, 8'd2);

        // Abort a frame after 6 rises by reset; CS_N released in the same cycle
        gpio[2] = 1'b0;
        hw(8);
        for (int i = 1; i <= 6; i++) begin
            gpio[1] = i[0];
            hw(8);
            gpio[0] = 1'b1;
            hw(8);
            gpio[0] = 1'b0;
        end
        hw(8);
        rst  = 1'b1;
        gpio = 3'b100;
        exp_err = 8'd0;
        hw(1);
        rst = 1'b0;
        hw(12);
        chk("err_cnt_after_rst", err_cnt, 8'd0);
        chk("sdi_after_rst", mcu_sdi, 1'b0);

        frame(1'b0, 7'h7F, 8'hFF, 16, 1'b0);
        hw(20);
        chk("err_cnt_final", err_cnt, exp_err);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
